// File: rtl/apb_exe_master.sv
// APB requester for the exe-unit slaves: one command at a time, one SETUP->ACCESS transfer,
// optionally chained with a read of address 0 so a single write command returns the ALU result.
module apb_exe_master #(
  parameter int SEL_WIDTH      = 3,
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  i_PCLK,
  input  logic                  i_PRESET,
  input  logic                  i_CMD_VALID,
  output logic                  o_CMD_READY,
  input  logic                  i_CMD_WRITE,
  input  logic                  i_CMD_AUTORD,
  input  logic [SEL_WIDTH-1:0]  i_CMD_SLAVE,
  input  logic [ADDR_WIDTH-1:0] i_CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] i_CMD_WDATA,
  output logic                  o_RSP_VALID,
  input  logic                  i_RSP_READY,
  output logic [DATA_WIDTH-1:0] o_RSP_RDATA,
  output logic [3:0]            o_RSP_ERR,
  output logic                  o_RSP_TOUT,
  output logic [SEL_WIDTH-1:0]  o_PSEL,
  output logic                  o_PENABLE,
  output logic                  o_PWRITE,
  output logic [ADDR_WIDTH-1:0] o_PADDR,
  output logic [DATA_WIDTH-1:0] o_PWDATA,
  input  logic                  i_PREADY,
  input  logic [DATA_WIDTH-1:0] i_PRDATA,
  input  logic [3:0]            i_PSLVERR
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] TOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t               state;
  state_t               state_next;
  logic                 autord_q;
  logic [CNT_WIDTH-1:0] tout_cnt;
  logic                 chain_read;
  logic                 timed_out;

  // Only the write phase can chain: the follow-up read drives PWRITE low, which ends the chain.
  assign chain_read  = o_PWRITE && autord_q && (i_PSLVERR == 4'd0);
  assign timed_out   = !i_PREADY && (tout_cnt == TOUT_LAST);
  assign o_CMD_READY = (state == IDLE);

  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_CMD_VALID) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS: begin
        if (i_PREADY)       state_next = chain_read ? SETUP : RESP;
        else if (timed_out) state_next = RESP;
      end
      RESP:    if (o_RSP_VALID && i_RSP_READY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // APB request, response fields and timeout counter; every output here is a register.
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      o_PSEL      <= '0;
      o_PENABLE   <= 1'b0;
      o_PWRITE    <= 1'b0;
      o_PADDR     <= '0;
      o_PWDATA    <= '0;
      o_RSP_VALID <= 1'b0;
      o_RSP_RDATA <= '0;
      o_RSP_ERR   <= 4'd0;
      o_RSP_TOUT  <= 1'b0;
      autord_q    <= 1'b0;
      tout_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_CMD_VALID) begin
            o_PSEL    <= i_CMD_SLAVE;
            o_PENABLE <= 1'b0;
            o_PWRITE  <= i_CMD_WRITE;
            o_PADDR   <= i_CMD_ADDR;
            o_PWDATA  <= i_CMD_WDATA;
            autord_q  <= i_CMD_WRITE && i_CMD_AUTORD;
            tout_cnt  <= '0;
          end
        end
        SETUP: o_PENABLE <= 1'b1;
        ACCESS: begin
          if (i_PREADY) begin
            o_RSP_ERR   <= i_PSLVERR;
            o_RSP_TOUT  <= 1'b0;
            o_RSP_RDATA <= o_PWRITE ? '0 : i_PRDATA;
            o_PENABLE   <= 1'b0;
            if (chain_read) begin
              o_PWRITE <= 1'b0;
              o_PADDR  <= '0;
              o_PWDATA <= '0;
              tout_cnt <= '0;
            end else begin
              o_PSEL <= '0;
            end
          end else if (timed_out) begin
            o_PSEL      <= '0;
            o_PENABLE   <= 1'b0;
            o_RSP_TOUT  <= 1'b1;
            o_RSP_ERR   <= 4'd0;
            o_RSP_RDATA <= '0;
          end else begin
            tout_cnt <= tout_cnt + CNT_WIDTH'(1);
          end
        end
        RESP: begin
          // Valid rises one cycle into RESP, so the bus always sees an idle cycle first.
          if (!o_RSP_VALID)     o_RSP_VALID <= 1'b1;
          else if (i_RSP_READY) o_RSP_VALID <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_exe_master.sv
// Randomized scoreboard bench for apb_exe_master with an in-bench APB responder and a
// transaction-level reference model of the response fields and latency.
module tb_apb_exe_master;

  localparam int SW = 3;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int TO = 15;
  localparam int NEVER = 1000;

  logic          i_PCLK = 1'b0;
  logic          i_PRESET;
  logic          i_CMD_VALID;
  logic          o_CMD_READY;
  logic          i_CMD_WRITE;
  logic          i_CMD_AUTORD;
  logic [SW-1:0] i_CMD_SLAVE;
  logic [AW-1:0] i_CMD_ADDR;
  logic [DW-1:0] i_CMD_WDATA;
  logic          o_RSP_VALID;
  logic          i_RSP_READY;
  logic [DW-1:0] o_RSP_RDATA;
  logic [3:0]    o_RSP_ERR;
  logic          o_RSP_TOUT;
  logic [SW-1:0] o_PSEL;
  logic          o_PENABLE;
  logic          o_PWRITE;
  logic [AW-1:0] o_PADDR;
  logic [DW-1:0] o_PWDATA;
  logic          i_PREADY;
  logic [DW-1:0] i_PRDATA;
  logic [3:0]    i_PSLVERR;

  apb_exe_master #(.SEL_WIDTH(SW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_PCLK(i_PCLK), .i_PRESET(i_PRESET),
    .i_CMD_VALID(i_CMD_VALID), .o_CMD_READY(o_CMD_READY), .i_CMD_WRITE(i_CMD_WRITE),
    .i_CMD_AUTORD(i_CMD_AUTORD), .i_CMD_SLAVE(i_CMD_SLAVE), .i_CMD_ADDR(i_CMD_ADDR),
    .i_CMD_WDATA(i_CMD_WDATA), .o_RSP_VALID(o_RSP_VALID), .i_RSP_READY(i_RSP_READY),
    .o_RSP_RDATA(o_RSP_RDATA), .o_RSP_ERR(o_RSP_ERR), .o_RSP_TOUT(o_RSP_TOUT),
    .o_PSEL(o_PSEL), .o_PENABLE(o_PENABLE), .o_PWRITE(o_PWRITE), .o_PADDR(o_PADDR),
    .o_PWDATA(o_PWDATA), .i_PREADY(i_PREADY), .i_PRDATA(i_PRDATA), .i_PSLVERR(i_PSLVERR)
  );

  always #5 i_PCLK = ~i_PCLK;

  typedef struct {
    logic [SW-1:0] sel;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [3:0]    err;
    logic [DW-1:0] rdata;
  } phase_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [3:0]    err;
    logic          tout;
    int            lat;
    int            acc;
  } rsp_t;

  phase_t phase_q[$];
  rsp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     hold_ready = 1'b0;

  always @(posedge i_PCLK) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic phase_t mk_phase(input logic [SW-1:0] sel, input logic wr,
                                      input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                                      input int w, input logic [3:0] e, input logic [DW-1:0] r);
    phase_t p;
    p.sel = sel; p.write = wr; p.addr = addr; p.wdata = wd;
    p.waits = w; p.err = e; p.rdata = r;
    return p;
  endfunction

  // APB slave: each ACCESS phase consumes one planned phase and checks the request it sees.
  initial begin
    phase_t cur;
    bit     active = 1'b0;
    int     wcnt = 0;
    cur = mk_phase('0, 1'b0, '0, '0, NEVER, 4'd0, '0);
    i_PREADY = 1'b0; i_PRDATA = '0; i_PSLVERR = 4'd0;
    forever begin
      @(negedge i_PCLK);
      i_PREADY  = 1'b0;
      i_PRDATA  = DW'($urandom);
      i_PSLVERR = 4'($urandom);
      if (o_PSEL != '0 && o_PENABLE) begin
        if (!active) begin
          if (phase_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL phase_plan actual=unplanned_access required=no_access psel=%0h", o_PSEL);
            cur = mk_phase(o_PSEL, o_PWRITE, o_PADDR, o_PWDATA, NEVER, 4'd0, '0);
          end else begin
            cur = phase_q.pop_front();
          end
          active = 1'b1;
          wcnt = 0;
        end
        check_output("apb_psel", o_PSEL, cur.sel);
        check_output("apb_pwrite", o_PWRITE, cur.write);
        check_output("apb_paddr", o_PADDR, cur.addr);
        check_output("apb_pwdata", o_PWDATA, cur.wdata);
        if (wcnt == cur.waits) begin
          i_PREADY = 1'b1; i_PRDATA = cur.rdata; i_PSLVERR = cur.err;
          active = 1'b0;
        end else begin
          wcnt++;
        end
      end else begin
        active = 1'b0;
      end
    end
  end

  initial begin
    i_RSP_READY = 1'b0;
    forever begin
      @(posedge i_PCLK);
      #1 i_RSP_READY = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: while a response is presented it must match the head of the scoreboard.
  initial begin
    bit held = 1'b0;
    forever begin
      @(negedge i_PCLK);
      if (o_RSP_VALID === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL rsp_unexpected actual=valid required=idle (t=%0t)", $time);
        end else begin
          if (!held) check_output("rsp_latency", cyc - exp_q[0].acc - 1, exp_q[0].lat);
          check_output("rsp_rdata", o_RSP_RDATA, exp_q[0].rdata);
          check_output("rsp_err", o_RSP_ERR, exp_q[0].err);
          check_output("rsp_tout", o_RSP_TOUT, exp_q[0].tout);
          check_output("rsp_cmd_ready", o_CMD_READY, 1'b0);
          if (i_RSP_READY) void'(exp_q.pop_front());
        end
      end
      held = (o_RSP_VALID === 1'b1) && !i_RSP_READY;
    end
  end

  task automatic send_cmd(input logic [SW-1:0] sel, input logic wr, input logic ar,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd, output int acc);
    int guard = 0;
    @(negedge i_PCLK);
    i_CMD_VALID = 1'b1; i_CMD_SLAVE = sel; i_CMD_WRITE = wr; i_CMD_AUTORD = ar;
    i_CMD_ADDR = addr; i_CMD_WDATA = wd;
    while (!o_CMD_READY && guard < 300) begin
      @(negedge i_PCLK);
      guard++;
    end
    if (!o_CMD_READY) begin
      checks++; errors++;
      $display("[TB] FAIL cmd_accept actual=not_ready required=ready_within_300");
      acc = -1;
      i_CMD_VALID = 1'b0;
    end else begin
      @(posedge i_PCLK);
      acc = cyc;
      #1 i_CMD_VALID = 1'b0;
      i_CMD_WDATA = DW'($urandom);
      i_CMD_ADDR  = AW'($urandom);
    end
  endtask

  // Reference model: a completed phase costs SETUP plus (waits+1) ACCESS cycles, an aborted
  // phase costs SETUP plus TO ACCESS cycles, and the response appears one cycle later.
  task automatic apply_stimulus(input logic [SW-1:0] sel, input logic wr, input logic ar,
                                input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                                input int w1, input logic [3:0] e1, input logic [DW-1:0] r1,
                                input int w2, input logic [3:0] e2, input logic [DW-1:0] r2);
    rsp_t exp;
    int   acc;
    exp.tout = 1'b0; exp.err = 4'd0; exp.rdata = '0; exp.lat = 1; exp.acc = 0;
    if (sel == '0) begin
      exp.tout = 1'b1; exp.lat += 1 + TO;
    end else begin
      phase_q.push_back(mk_phase(sel, wr, addr, wd, w1, e1, r1));
      if (w1 >= TO) begin
        exp.tout = 1'b1; exp.lat += 1 + TO;
      end else begin
        exp.lat += 2 + w1; exp.err = e1; exp.rdata = wr ? '0 : r1;
        if (wr && ar && e1 == 4'd0) begin
          phase_q.push_back(mk_phase(sel, 1'b0, '0, '0, w2, e2, r2));
          if (w2 >= TO) begin
            exp.tout = 1'b1; exp.err = 4'd0; exp.rdata = '0; exp.lat += 1 + TO;
          end else begin
            exp.lat += 2 + w2; exp.err = e2; exp.rdata = r2;
          end
        end
      end
    end
    send_cmd(sel, wr, ar, addr, wd, acc);
    exp.acc = acc;
    if (acc >= 0) exp_q.push_back(exp);
  endtask

  function automatic int pick_wait();
    int r = $urandom_range(0, 19);
    if (r < 12) return $urandom_range(0, 2);
    if (r < 16) return $urandom_range(3, 6);
    if (r == 16) return TO - 1;
    if (r == 17) return TO;
    if (r == 18) return TO - 2;
    return NEVER;
  endfunction

  task automatic wait_drained(input string name);
    int guard = 0;
    while ((exp_q.size() != 0 || phase_q.size() != 0) && guard < 500) begin
      @(negedge i_PCLK);
      guard++;
    end
    check_output({name, "_exp_q"}, exp_q.size(), 0);
    check_output({name, "_phase_q"}, phase_q.size(), 0);
  endtask

  initial begin
    int guard;
    int acc;
    i_PRESET = 1'b1; i_CMD_VALID = 1'b0; i_CMD_WRITE = 1'b0; i_CMD_AUTORD = 1'b0;
    i_CMD_SLAVE = '0; i_CMD_ADDR = '0; i_CMD_WDATA = '0;
    repeat (3) @(posedge i_PCLK);
    #1;
    check_output("rst_cmd_ready", o_CMD_READY, 1'b1);
    check_output("rst_rsp_valid", o_RSP_VALID, 1'b0);
    check_output("rst_psel", o_PSEL, 0);
    check_output("rst_penable", o_PENABLE, 1'b0);
    check_output("rst_rsp_fields", {o_RSP_RDATA, o_RSP_ERR, o_RSP_TOUT}, 0);
    i_PRESET = 1'b0;

    // Zero-wait write: SETUP then ACCESS, response three cycles after accept.
    apply_stimulus(3'b001, 1'b1, 1'b0, 2'b01, 8'h1A, 0, 4'd0, 8'h77, 0, 4'd0, 8'h00);
    check_output("t1_setup_psel", o_PSEL, 3'b001);
    check_output("t1_setup_penable", o_PENABLE, 1'b0);
    @(posedge i_PCLK);
    #1 check_output("t1_access_penable", o_PENABLE, 1'b1);
    // Read with two wait states.
    apply_stimulus(3'b010, 1'b0, 1'b0, 2'b00, 8'h00, 2, 4'd0, 8'h34, 0, 4'd0, 8'h00);
    // Write with chained read of address 0.
    apply_stimulus(3'b100, 1'b1, 1'b1, 2'b11, 8'h0A, 0, 4'd0, 8'h00, 0, 4'd0, 8'h14);
    // Write error suppresses the chained read.
    apply_stimulus(3'b001, 1'b1, 1'b1, 2'b10, 8'h5C, 0, 4'b0010, 8'h00, 0, 4'd0, 8'h99);
    wait_drained("directed");

    // Silent slave: abort, then a response held for several cycles.
    hold_ready = 1'b1;
    apply_stimulus(3'b001, 1'b0, 1'b0, 2'b01, 8'h00, NEVER, 4'd0, 8'h00, 0, 4'd0, 8'h00);
    guard = 0;
    while (o_RSP_VALID !== 1'b1 && guard < 40) begin
      @(negedge i_PCLK);
      guard++;
    end
    check_output("tout_rsp_valid", o_RSP_VALID, 1'b1);
    check_output("tout_psel", o_PSEL, 0);
    repeat (5) @(negedge i_PCLK);
    hold_ready = 1'b0;
    wait_drained("timeout");

    // Reset in the middle of ACCESS drops the transfer and any response.
    phase_q.push_back(mk_phase(3'b010, 1'b1, 2'b10, 8'h55, NEVER, 4'd0, 8'h00));
    send_cmd(3'b010, 1'b1, 1'b0, 2'b10, 8'h55, acc);
    repeat (3) @(posedge i_PCLK);
    #1 check_output("mid_penable", o_PENABLE, 1'b1);
    i_PRESET = 1'b1;
    @(posedge i_PCLK);
    #1;
    check_output("midrst_psel", o_PSEL, 0);
    check_output("midrst_penable", o_PENABLE, 1'b0);
    check_output("midrst_cmd_ready", o_CMD_READY, 1'b1);
    check_output("midrst_rsp_valid", o_RSP_VALID, 1'b0);
    i_PRESET = 1'b0;
    repeat (20) @(negedge i_PCLK);
    wait_drained("midrst");

    for (int i = 0; i < 150; i++) begin
      logic [SW-1:0] sel;
      logic [3:0]    e1;
      logic [3:0]    e2;
      sel = ($urandom_range(0, 15) == 0) ? '0 : SW'(1 << $urandom_range(0, SW - 1));
      e1  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      e2  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      repeat ($urandom_range(0, 2)) @(posedge i_PCLK);
      apply_stimulus(sel, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
                     pick_wait(), e1, DW'($urandom), pick_wait(), e2, DW'($urandom));
    end
    wait_drained("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
